cache_victim_scheduler: RTL and testbench

//  Picks the victim way for each cache fill request in the set-associative cache.

---
 rtl/cache_victim_scheduler_pkg.sv | 21 ++
 rtl/cache_victim_scheduler_gray.sv | 29 ++
 rtl/cache_victim_scheduler.sv | 168 ++++++++++++++++
 tb/tb_cache_victim_scheduler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_victim_scheduler_pkg.sv
// Shared definitions for the victim scheduler: default geometry, FSM encodings
// and the priority encoder used to find the first free way.
package cache_victim_scheduler_pkg;

    localparam int unsigned CVS_WAYS  = 4;
    localparam int unsigned CVS_WAY_W = 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [CVS_WAY_W-1:0] lowest_set(input logic [CVS_WAYS-1:0] mask);
        lowest_set = '0;
        for (int i = CVS_WAYS - 1; i >= 0; i--) begin
            if (mask[i]) lowest_set = CVS_WAY_W'(i);
        end
    endfunction

endpackage

// File: rtl/cache_victim_scheduler_gray.sv
// Free-running Gray-code pointer; advances by one code on each en_i pulse.
module cache_victim_scheduler_gray #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             not_reset,
    input  logic             en_i,
    output logic [WIDTH-1:0] value_o
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;

    assign bin_d = bin_q + WIDTH'(1);

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else if (en_i) begin
            bin_q  <= bin_d;
            gray_q <= bin_d ^ (bin_d >> 1);
        end
    end

    assign value_o = gray_q;

endmodule

// File: rtl/cache_victim_scheduler.sv
// Victim way selection for cache fills: hit way, else first free unlocked way,
// else the next unlocked way along a Gray-coded pseudo-random pointer.
module cache_victim_scheduler
    import cache_victim_scheduler_pkg::*;
#(
    parameter int unsigned WAYS  = CVS_WAYS,
    parameter int unsigned WAY_W = CVS_WAY_W
) (
    input  logic             clk,
    input  logic             not_reset,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             hit_i,
    input  logic [WAY_W-1:0] hit_way_i,
    input  logic [WAYS-1:0]  valid_mask_i,
    input  logic [WAYS-1:0]  lock_mask_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic [WAY_W-1:0] victim_way_o,
    output logic             resp_evict_o,
    output logic             resp_fail_o
);

    localparam int unsigned STEP_W = WAY_W + 1;

    logic [1:0]        state_q,      state_d;
    logic              hit_q,        hit_d;
    logic [WAY_W-1:0]  hit_way_q,    hit_way_d;
    logic [WAYS-1:0]   valid_q,      valid_d;
    logic [WAYS-1:0]   lock_q,       lock_d;
    logic [STEP_W-1:0] step_q,       step_d;
    logic              req_ready_q,  req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [WAY_W-1:0]  victim_q,     victim_d;
    logic              evict_q,      evict_d;
    logic              fail_q,       fail_d;

    logic [WAYS-1:0]   free_c;
    logic              ptr_en_c;
    logic [WAY_W-1:0]  ptr;

    cache_victim_scheduler_gray #(.WIDTH(WAY_W)) u_ptr (
        .clk      (clk),
        .not_reset(not_reset),
        .en_i     (ptr_en_c),
        .value_o  (ptr)
    );

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state_q      <= ST_IDLE;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            valid_q      <= '0;
            lock_q       <= '0;
            step_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            victim_q     <= '0;
            evict_q      <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hit_q        <= hit_d;
            hit_way_q    <= hit_way_d;
            valid_q      <= valid_d;
            lock_q       <= lock_d;
            step_q       <= step_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            victim_q     <= victim_d;
            evict_q      <= evict_d;
            fail_q       <= fail_d;
        end
    end

    // Next-state and next-output logic; ptr_en_c is the scan-step or commit pulse.
    always_comb begin
        state_d      = state_q;
        hit_d        = hit_q;
        hit_way_d    = hit_way_q;
        valid_d      = valid_q;
        lock_d       = lock_q;
        step_d       = step_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        victim_d     = victim_q;
        evict_d      = evict_q;
        fail_d       = fail_q;
        ptr_en_c     = 1'b0;
        free_c       = ~valid_q & ~lock_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    hit_d       = hit_i;
                    hit_way_d   = hit_way_i;
                    valid_d     = valid_mask_i;
                    lock_d      = lock_mask_i;
                    req_ready_d = 1'b0;
                    state_d     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                evict_d = 1'b0;
                fail_d  = 1'b0;
                if (hit_q) begin
                    victim_d     = hit_way_q;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else if (|free_c) begin
                    victim_d     = WAY_W'(lowest_set(CVS_WAYS'(free_c)));
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else if (&lock_q) begin
                    victim_d     = '0;
                    fail_d       = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else if (!lock_q[ptr]) begin
                    victim_d     = ptr;
                    evict_d      = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    ptr_en_c = 1'b1;
                    step_d   = STEP_W'(1);
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!lock_q[ptr]) begin
                    victim_d     = ptr;
                    evict_d      = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else if (step_q >= STEP_W'(WAYS)) begin
                    victim_d     = '0;
                    fail_d       = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = ST_RESP;
                end else begin
                    ptr_en_c = 1'b1;
                    step_d   = step_q + STEP_W'(1);
                end
            end
            ST_RESP: begin
                // Evicting commits the victim: step the pointer past it.
                if (resp_ready_i) begin
                    ptr_en_c     = evict_q;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign victim_way_o = victim_q;
    assign resp_evict_o = evict_q;
    assign resp_fail_o  = fail_q;

endmodule

// File: tb/tb_cache_victim_scheduler.sv
// Directed bench for cache_victim_scheduler with a replacement-policy model and a
// per-cycle response checker.
module tb_cache_victim_scheduler;

    localparam int unsigned WAYS  = 4;
    localparam int unsigned WAY_W = 2;

    logic             clk = 1'b0;
    logic             not_reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             hit = 1'b0;
    logic [WAY_W-1:0] hit_way = '0;
    logic [WAYS-1:0]  valid_mask = '0;
    logic [WAYS-1:0]  lock_mask = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [WAY_W-1:0] victim_way;
    logic             resp_evict;
    logic             resp_fail;

    cache_victim_scheduler dut (
        .clk         (clk),
        .not_reset   (not_reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .hit_i       (hit),
        .hit_way_i   (hit_way),
        .valid_mask_i(valid_mask),
        .lock_mask_i (lock_mask),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .victim_way_o(victim_way),
        .resp_evict_o(resp_evict),
        .resp_fail_o (resp_fail)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: number of pointer advances since reset; pointer = gray(advances mod WAYS).
    int mcount = 0;
    int exp_victim, exp_evict, exp_fail, exp_lat, exp_acc;
    bit exp_pending = 1'b0;
    bit seen = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int gray(input int n);
        int b;
        b = n % WAYS;
        return b ^ (b >> 1);
    endfunction

    task automatic predict(input logic h, input int hw, input logic [WAYS-1:0] vm,
                           input logic [WAYS-1:0] lm, output int v, output int e,
                           output int f, output int lat, output int adv);
        v = 0; e = 0; f = 0; lat = 2; adv = 0;
        if (h) begin
            v = hw;
            return;
        end
        for (int i = 0; i < WAYS; i++) begin
            if (!vm[i] && !lm[i]) begin
                v = i;
                return;
            end
        end
        if (lm == {WAYS{1'b1}}) begin
            f = 1;
            return;
        end
        for (int k = 0; k < WAYS; k++) begin
            if (!lm[gray(mcount + k)]) begin
                v = gray(mcount + k);
                e = 1;
                lat = 2 + k;
                adv = k + 1;
                return;
            end
        end
    endtask

    // Response checker: every cycle a response is up, it must match the model.
    always @(negedge clk) begin
        if (not_reset && resp_valid) begin
            if (!exp_pending) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                if (!seen) begin
                    chk("latency", cyc - exp_acc, exp_lat);
                    seen = 1'b1;
                end
                chk("victim_way", int'(victim_way), exp_victim);
                chk("resp_evict", int'(resp_evict), exp_evict);
                chk("resp_fail", int'(resp_fail), exp_fail);
                chk("ready_while_resp", int'(req_ready), 0);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 1);
        chk({tag, "_resp_valid"}, int'(resp_valid), 0);
        chk({tag, "_victim"}, int'(victim_way), 0);
        chk({tag, "_evict"}, int'(resp_evict), 0);
        chk({tag, "_fail"}, int'(resp_fail), 0);
    endtask

    task automatic do_reset();
        not_reset   = 1'b0;
        req_valid   = 1'b0;
        resp_ready  = 1'b0;
        exp_pending = 1'b0;
        mcount      = 0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        not_reset = 1'b1;
    endtask

    // Issue one request; ev/ee/ef/el are hand-computed and pin the model.
    task automatic do_req(input logic h, input int hw, input logic [WAYS-1:0] vm,
                          input logic [WAYS-1:0] lm, input int hold,
                          input int ev, input int ee, input int ef, input int el);
        int pv, pe, pf, pl, padv, n;
        predict(h, hw, vm, lm, pv, pe, pf, pl, padv);
        chk("model_victim", pv, ev);
        chk("model_evict", pe, ee);
        chk("model_fail", pf, ef);
        chk("model_latency", pl, el);
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 0, 1);
            return;
        end
        req_valid  = 1'b1;
        hit        = h;
        hit_way    = WAY_W'(hw);
        valid_mask = vm;
        lock_mask  = lm;
        exp_victim = pv; exp_evict = pe; exp_fail = pf; exp_lat = pl;
        exp_acc    = cyc;
        seen       = 1'b0;
        exp_pending = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            chk("resp_timeout", 0, 1);
            exp_pending = 1'b0;
            return;
        end
        // While stalled, a competing request must be ignored.
        for (int i = 0; i < hold; i++) begin
            req_valid  = 1'b1;
            hit        = 1'b1;
            hit_way    = WAY_W'(i);
            valid_mask = '0;
            lock_mask  = '1;
            @(negedge clk);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_dropped", int'(resp_valid), 0);
        chk("ready_after_ack", int'(req_ready), 1);
        exp_pending = 1'b0;
        mcount += padv;
    endtask

    initial begin
        do_reset();
        // Hit wins; pointer untouched.
        do_req(1'b1, 2, 4'b1111, 4'b0000, 0, 2, 0, 0, 2);
        do_req(1'b0, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 2);

        // First invalid way, pointer not advanced.
        do_reset();
        do_req(1'b0, 0, 4'b1011, 4'b0000, 0, 2, 0, 0, 2);
        do_req(1'b0, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 2);

        // Gray walk 0,1,3,2,0.
        do_reset();
        do_req(1'b0, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 2);
        do_req(1'b0, 0, 4'b1111, 4'b0000, 0, 1, 1, 0, 2);
        do_req(1'b0, 0, 4'b1111, 4'b0000, 0, 3, 1, 0, 2);
        do_req(1'b0, 0, 4'b1111, 4'b0000, 0, 2, 1, 0, 2);
        do_req(1'b0, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 2);

        // Locked pointer position skipped.
        do_reset();
        do_req(1'b0, 0, 4'b1111, 4'b0001, 0, 1, 1, 0, 3);
        do_req(1'b0, 0, 4'b1111, 4'b0000, 0, 3, 1, 0, 2);

        // All locked fails without moving the pointer; locks ignored on hit.
        do_reset();
        do_req(1'b0, 0, 4'b1111, 4'b1111, 0, 0, 0, 1, 2);
        do_req(1'b1, 3, 4'b1111, 4'b1111, 0, 3, 0, 0, 2);
        do_req(1'b0, 0, 4'b0110, 4'b0001, 0, 3, 0, 0, 2);
        do_req(1'b0, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 2);

        // Stalled response, then a two-step scan from pointer position 1.
        do_reset();
        do_req(1'b0, 0, 4'b1111, 4'b0000, 10, 0, 1, 0, 2);
        do_req(1'b0, 0, 4'b1111, 4'b1011, 0, 2, 1, 0, 4);
        do_req(1'b0, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 2);

        // Reset while scanning aborts the request.
        do_reset();
        @(negedge clk);
        chk("pre_scan_ready", int'(req_ready), 1);
        req_valid  = 1'b1;
        hit        = 1'b0;
        valid_mask = 4'b1111;
        lock_mask  = 4'b0111;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_scan_no_resp", int'(resp_valid), 0);
        not_reset = 1'b0;
        mcount    = 0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        not_reset = 1'b1;
        do_req(1'b0, 0, 4'b1111, 4'b0000, 0, 0, 1, 0, 2);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
